// File: rtl/btn_event_pkg.sv
// Shared types and defaults for the button event sequencer.
// The auto-repeat feature is controlled by BTN_EVENT_CTRL_AUTO_REPEAT_EN.
package btn_event_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD,
        WAIT_REL
    } btn_state_t;

    localparam int unsigned LONG_TICKS_DEF   = 500;
    localparam int unsigned REPEAT_TICKS_DEF = 100;

    // Counter only has to reach max(long, repeat) - 1.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/btn_press_fsm.sv
// Per-button press classifier: short / long / auto-repeat events.
// Repeat counting in HELD exists only with BTN_EVENT_CTRL_AUTO_REPEAT_EN defined.
module btn_press_fsm
    import btn_event_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF,
    parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       btn_i,
    input  logic       force_wait_i,
    output btn_state_t state_o,
    output logic       short_o,
    output logic       long_o,
    output logic       rpt_o
);

    localparam int unsigned CNT_W = cnt_width(LONG_TICKS, REPEAT_TICKS);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_EVENT_CTRL_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        if (force_wait_i) begin
            // Combo gesture swallows any event this button would have produced.
            state_d = WAIT_REL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (btn_i) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (!btn_i) begin
                        short_d = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (en_i) begin
                        if (cnt_q == LONG_LAST) begin
                            long_d  = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!btn_i) begin
                        state_d = IDLE;
                        cnt_d   = '0;
`ifdef BTN_EVENT_CTRL_AUTO_REPEAT_EN
                    end else if (en_i) begin
                        if (cnt_q == RPT_LAST) begin
                            rpt_d = 1'b1;
                            cnt_d = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
`endif
                    end
                end
                WAIT_REL: begin
                    if (!btn_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = WAIT_REL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= WAIT_REL;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
        end
    end

    assign state_o = state_q;
    assign short_o = short_q;
    assign long_o  = long_q;
    assign rpt_o   = rpt_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// Two-button event sequencer: per-button classifiers plus combo detection and busy flag.
// Auto-repeat is enabled by defining BTN_EVENT_CTRL_AUTO_REPEAT_EN.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int unsigned LONG_TICKS   = LONG_TICKS_DEF,
    parameter int unsigned REPEAT_TICKS = REPEAT_TICKS_DEF,
    parameter int unsigned NBTN         = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en_i,
    input  logic [NBTN-1:0] btn_i,
    output logic [NBTN-1:0] short_o,
    output logic [NBTN-1:0] long_o,
    output logic [NBTN-1:0] rpt_o,
    output logic            combo_o,
    output logic            busy_o
);

    btn_state_t fsm_state [NBTN];
    logic       combo_hit;
    logic       any_pressed;
    logic       busy_d;
    logic       combo_q;
    logic       busy_q;

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        btn_press_fsm #(
            .LONG_TICKS   (LONG_TICKS),
            .REPEAT_TICKS (REPEAT_TICKS)
        ) u_fsm (
            .clk          (clk),
            .rst          (rst),
            .en_i         (en_i),
            .btn_i        (btn_i[i]),
            .force_wait_i (combo_hit),
            .state_o      (fsm_state[i]),
            .short_o      (short_o[i]),
            .long_o       (long_o[i]),
            .rpt_o        (rpt_o[i])
        );
    end

    // Every button must be held and either PRESSED or just leaving IDLE, with at
    // least one already PRESSED; a releasing button therefore blocks the combo.
    always_comb begin
        combo_hit   = 1'b1;
        any_pressed = 1'b0;
        busy_d      = 1'b0;
        for (int i = 0; i < NBTN; i++) begin
            combo_hit   = combo_hit & btn_i[i] &
                          ((fsm_state[i] == IDLE) || (fsm_state[i] == PRESSED));
            any_pressed = any_pressed | (fsm_state[i] == PRESSED);
            busy_d      = busy_d | (fsm_state[i] != IDLE);
        end
        combo_hit = combo_hit & any_pressed;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            combo_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            combo_q <= combo_hit;
            busy_q  <= busy_d;
        end
    end

    assign combo_o = combo_q;
    assign busy_o  = busy_q;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed and randomized bench for btn_event_ctrl against a tick-count reference model.
module tb_btn_event_ctrl;

    localparam int LT = 5;
    localparam int RT = 2;
`ifdef BTN_EVENT_CTRL_AUTO_REPEAT_EN
    localparam bit RPT_EN = 1'b1;
`else
    localparam bit RPT_EN = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_PRESS = 1;
    localparam int P_HELD  = 2;
    localparam int P_WAIT  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] btn;
    logic [1:0] short_o, long_o, rpt_o;
    logic       combo_o, busy_o;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: phase per button plus total ticks held since the press.
    int         ph [2];
    int         t  [2];
    logic [1:0] e_short, e_long, e_rpt;
    logic       e_combo, e_busy;

    int n_s0, n_s1, n_l0, n_l1, n_r0, n_r1, n_c;

    btn_event_ctrl #(
        .LONG_TICKS   (LT),
        .REPEAT_TICKS (RT),
        .NBTN         (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en_i    (en),
        .btn_i   (btn),
        .short_o (short_o),
        .long_o  (long_o),
        .rpt_o   (rpt_o),
        .combo_o (combo_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_bits(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_step(input logic r, input logic [1:0] b, input logic e);
        bit combo;
        bit any_press;
        if (!r) begin
            for (int i = 0; i < 2; i++) begin
                ph[i] = P_WAIT;
                t[i]  = 0;
            end
            e_short = '0;
            e_long  = '0;
            e_rpt   = '0;
            e_combo = 1'b0;
            e_busy  = 1'b0;
        end else begin
            combo     = 1'b1;
            any_press = 1'b0;
            for (int i = 0; i < 2; i++) begin
                combo     = combo && b[i] && (ph[i] == P_IDLE || ph[i] == P_PRESS);
                any_press = any_press || (ph[i] == P_PRESS);
            end
            combo   = combo && any_press;
            e_busy  = (ph[0] != P_IDLE) || (ph[1] != P_IDLE);
            e_combo = combo;
            e_short = '0;
            e_long  = '0;
            e_rpt   = '0;
            for (int i = 0; i < 2; i++) begin
                if (combo) begin
                    ph[i] = P_WAIT;
                    t[i]  = 0;
                end else begin
                    case (ph[i])
                        P_IDLE: if (b[i]) begin
                            ph[i] = P_PRESS;
                            t[i]  = 0;
                        end
                        P_PRESS: if (!b[i]) begin
                            e_short[i] = 1'b1;
                            ph[i]      = P_IDLE;
                        end else if (e) begin
                            t[i]++;
                            if (t[i] == LT) begin
                                e_long[i] = 1'b1;
                                ph[i]     = P_HELD;
                            end
                        end
                        P_HELD: if (!b[i]) begin
                            ph[i] = P_IDLE;
                        end else if (e && RPT_EN) begin
                            t[i]++;
                            if ((t[i] - LT) % RT == 0) e_rpt[i] = 1'b1;
                        end
                        default: if (!b[i]) ph[i] = P_IDLE;
                    endcase
                end
            end
        end
    endtask

    task automatic tick(input logic r, input logic [1:0] b);
        logic e;
        e   = (cyc % 4) == 3;
        rst = r;
        btn = b;
        en  = e;
        @(posedge clk);
        model_step(r, b, e);
        #1;
        check_bits("outputs", {busy_o, combo_o, rpt_o, long_o, short_o},
                   {e_busy, e_combo, e_rpt, e_long, e_short});
        if (short_o[0]) n_s0++;
        if (short_o[1]) n_s1++;
        if (long_o[0])  n_l0++;
        if (long_o[1])  n_l1++;
        if (rpt_o[0])   n_r0++;
        if (rpt_o[1])   n_r1++;
        if (combo_o)    n_c++;
        cyc++;
    endtask

    task automatic hold(input logic [1:0] b, input int n);
        for (int k = 0; k < n; k++) tick(1'b1, b);
    endtask

    task automatic clear_counts();
        n_s0 = 0; n_s1 = 0; n_l0 = 0; n_l1 = 0; n_r0 = 0; n_r1 = 0; n_c = 0;
    endtask

    initial begin
        // Button held through reset: silent until released, busy drops a cycle later.
        tick(1'b0, 2'b01);
        check_bits("reset_outputs", {busy_o, combo_o, rpt_o, long_o, short_o}, 8'h00);
        tick(1'b0, 2'b01);
        tick(1'b0, 2'b01);
        clear_counts();
        hold(2'b01, 40);
        check_int("held_through_reset_busy", int'(busy_o), 1);
        tick(1'b1, 2'b00);
        check_int("busy_after_drop", int'(busy_o), 1);
        tick(1'b1, 2'b00);
        check_int("busy_fall", int'(busy_o), 0);
        hold(2'b00, 6);
        check_int("reset_hold_events", n_s0 + n_s1 + n_l0 + n_l1 + n_r0 + n_r1 + n_c, 0);

        // Short press on button 0.
        clear_counts();
        hold(2'b01, 12);
        hold(2'b00, 8);
        check_int("short0_count", n_s0, 1);
        check_int("short0_no_long", n_l0 + n_l1, 0);
        check_int("short0_no_combo", n_c, 0);

        // Long hold on button 1, with repeats when enabled.
        clear_counts();
        hold(2'b10, 49);
        hold(2'b00, 8);
        check_int("long1_count", n_l1, 1);
        check_int("rpt1_count", n_r1, RPT_EN ? 3 : 0);
        check_int("long1_no_short", n_s0 + n_s1, 0);

        // Combo: btn0 first, btn1 two ticks later.
        clear_counts();
        hold(2'b01, 9);
        hold(2'b11, 40);
        check_int("combo_busy", int'(busy_o), 1);
        hold(2'b00, 8);
        check_int("combo_count", n_c, 1);
        check_int("combo_no_other", n_s0 + n_s1 + n_l0 + n_l1 + n_r0 + n_r1, 0);

        // Release of btn0 on the same clock btn1 rises: no combo.
        clear_counts();
        hold(2'b01, 6);
        hold(2'b10, 8);
        hold(2'b00, 8);
        check_int("handoff_short0", n_s0, 1);
        check_int("handoff_short1", n_s1, 1);
        check_int("handoff_no_combo", n_c, 0);

        // Random gestures with occasional resets.
        for (int seg = 0; seg < 200; seg++) begin
            if ($urandom_range(0, 40) == 0) begin
                tick(1'b0, 2'($urandom_range(0, 3)));
            end else begin
                hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 40)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
